// File: rtl/ysyx_24100006_defs.sv
// Shared definitions for the ysyx_24100006 core.
// IFU state encoding, reset PC and instruction width.
package ysyx_24100006_defs;

  localparam int unsigned INST_W = 32;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ysyx_24100006_ifu.sv
// Instruction fetch unit: one outstanding read, result
// handed to IF/ID over valid/ready, redirects kill stale fetches.
module ysyx_24100006_ifu
  import ysyx_24100006_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_req_addr,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [INST_W-1:0] mem_resp_data,
  input  logic              mem_resp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       pc_o,
  output logic [INST_W-1:0] instruction_o,
  output logic              fault_o
);

  ifu_state_e        state, state_n;
  logic [31:0]       pc, pc_n;
  logic              drop, drop_n;
  logic [INST_W-1:0] inst_n;
  logic              fault_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_REQ;
      pc            <= RESET_PC;
      drop          <= 1'b0;
      instruction_o <= '0;
      fault_o       <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      drop          <= drop_n;
      instruction_o <= inst_n;
      fault_o       <= fault_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    inst_n  = instruction_o;
    fault_n = fault_o;
    unique case (state)
      S_REQ: begin
        if (mem_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          if (drop) begin
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            inst_n  = mem_resp_data;
            fault_n = mem_resp_err;
            state_n = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          pc_n    = pc + PC_STEP;
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase

    // Redirect wins: any in-flight response is marked stale.
    if (redirect_i) begin
      pc_n    = redirect_pc_i & ~32'h3;
      inst_n  = instruction_o;
      fault_n = fault_o;
      unique case (state)
        S_REQ: begin
          if (mem_req_ready) begin
            state_n = S_WAIT;
            drop_n  = 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            state_n = S_REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  assign mem_req_valid  = (state == S_REQ);
  assign mem_resp_ready = (state == S_WAIT);
  assign out_valid      = (state == S_OUT);
  assign mem_req_addr   = pc;
  assign pc_o           = pc;

endmodule

// File: tb/tb_ysyx_24100006_ifu.sv
// Scoreboard bench for the instruction fetch unit.
// Responses are queued as driven and popped when out_valid rises.
module tb_ysyx_24100006_ifu;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_o;
  logic [31:0] instruction_o;
  logic        fault_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        f;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  ysyx_24100006_ifu dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pc_o           (pc_o),
    .instruction_o  (instruction_o),
    .fault_o        (fault_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check();
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("sb_size", sb.size(), 32'd1);
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      chk("pc_o", pc_o, cur.pc);
      chk("inst_o", instruction_o, cur.ins);
      chk("fault_o", {31'd0, fault_o}, {31'd0, cur.f});
    end
  endtask

  // Drive one fetch from S_REQ through to S_OUT.
  task automatic fetch(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic        e,
                       input int          lat,
                       input int          hold,
                       input bit          rel);
    chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("req_addr", mem_req_addr, a);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("resp_ready", {31'd0, mem_resp_ready}, 32'd1);
    repeat (lat) begin
      chk("wait_out", {31'd0, out_valid}, 32'd0);
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    mem_resp_err   = e;
    sb.push_back('{pc: a, ins: d, f: e});
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    pop_check();
    repeat (hold) begin
      tick();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_pc", pc_o, cur.pc);
      chk("hold_inst", instruction_o, cur.ins);
      chk("hold_fault", {31'd0, fault_o}, {31'd0, cur.f});
      chk("hold_noreq", {31'd0, mem_req_valid}, 32'd0);
    end
    if (rel) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic expect_req(input string tag, input logic [31:0] a);
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rv"}, {31'd0, mem_req_valid}, 32'd1);
    chk({tag, "_ra"}, mem_req_addr, a);
  endtask

  initial begin
    reset          = 1'b1;
    redirect_i     = 1'b0;
    redirect_pc_i  = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
    out_ready      = 1'b0;
    tick();
    tick();
    chk("rst_inst", instruction_o, 32'd0);
    chk("rst_fault", {31'd0, fault_o}, 32'd0);
    expect_req("rst", RST_PC);
    reset = 1'b0;
    tick();
    expect_req("post_rst", RST_PC);

    fetch(32'h8000_0000, 32'h0000_0413, 1'b0, 0, 0, 1'b1);
    fetch(32'h8000_0004, 32'h0010_0093, 1'b0, 2, 5, 1'b1);
    fetch(32'h8000_0008, 32'h1234_5678, 1'b1, 1, 0, 1'b1);
    fetch(32'h8000_000C, 32'h0000_0013, 1'b0, 0, 0, 1'b1);

    // Redirect while waiting; response three cycles later is dropped.
    chk("rw_addr", mem_req_addr, 32'h8000_0010);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h8000_0103;
    tick();
    redirect_i = 1'b0;
    repeat (2) begin
      chk("rw_nov", {31'd0, out_valid}, 32'd0);
      chk("rw_rr", {31'd0, mem_resp_ready}, 32'd1);
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEAD_BEEF;
    tick();
    mem_resp_valid = 1'b0;
    expect_req("rw", 32'h8000_0100);

    // Redirect coincident with the response.
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hAAAA_5555;
    redirect_i     = 1'b1;
    redirect_pc_i  = 32'h8000_0200;
    tick();
    mem_resp_valid = 1'b0;
    redirect_i     = 1'b0;
    expect_req("rresp", 32'h8000_0200);

    // Redirect coincident with out_ready: no pc increment.
    fetch(32'h8000_0200, 32'h0020_0113, 1'b0, 1, 0, 1'b0);
    out_ready     = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h8000_0300;
    tick();
    out_ready  = 1'b0;
    redirect_i = 1'b0;
    expect_req("rout", 32'h8000_0300);

    // Redirect while the request handshakes.
    mem_req_ready = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h8000_0401;
    tick();
    mem_req_ready = 1'b0;
    redirect_i    = 1'b0;
    chk("rreq_rr", {31'd0, mem_resp_ready}, 32'd1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0BAD_0BAD;
    tick();
    mem_resp_valid = 1'b0;
    expect_req("rreq", 32'h8000_0400);

    fetch(32'h8000_0400, 32'h0030_0193, 1'b0, 0, 0, 1'b1);

    // Reset during an outstanding fetch.
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_req("rst_wait", RST_PC);

    // PC wraps at the top of the address space.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    fetch(32'hFFFF_FFFC, 32'h0000_0073, 1'b0, 0, 0, 1'b1);
    expect_req("wrap", 32'h0000_0000);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_ifu.md
Name: ysyx_24100006_ifu

Overview:
- Instruction fetch unit; the producer side of the IF/ID stage register.
- Holds the PC and issues one read per instruction on a simple request/response memory bus.
- Presents {pc, instruction, fault} to IF/ID over a valid/ready handshake.
- Accepts redirects from EXU/WBU (branch, jump, trap, mret) and discards any stale fetch in flight.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
PC_STEP, 4, sequential PC increment

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
redirect_i  input  1  redirect request, single-cycle pulse
redirect_pc_i  input  32  redirect target; bits [1:0] ignored and forced to 0
mem_req_valid  output  1  read request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  32  read address (= pc)
mem_resp_valid  input  1  read data valid
mem_resp_ready  output  1  IFU accepts response
mem_resp_data  input  32  instruction word
mem_resp_err  input  1  bus error on this response
out_valid  output  1  fetched instruction valid, to IF/ID
out_ready  input  1  IF/ID can accept
pc_o  output  32  PC of the presented instruction
instruction_o  output  32  presented instruction
fault_o  output  1  instruction carries a fetch bus error

Behaviour:
- Reset, synchronous: state=S_REQ, pc=RESET_PC, drop=0, instruction_o=0, fault_o=0, out_valid=0. mem_req_valid=1 in the first cycle after reset deasserts. The memory side is reset by the same reset, so no response survives reset. A reset in the middle of a fetch aborts it unconditionally.
- Single outstanding request; no prefetch.
- Outputs decode from state:
  - mem_req_valid = (state==S_REQ)
  - mem_resp_ready = (state==S_WAIT)
  - out_valid = (state==S_OUT)
  - mem_req_addr = pc
- S_REQ:
  - On mem_req_ready → S_WAIT.
  - mem_req_addr may change while the request is unaccepted; it changes only on a redirect.
- S_WAIT:
  - On mem_resp_valid with drop=0: latch data into instruction_o and mem_resp_err into fault_o → S_OUT.
  - On mem_resp_valid with drop=1: discard the response, clear drop → S_REQ, using the already-updated pc.
- S_OUT:
  - pc_o, instruction_o and fault_o are held stable while out_valid && !out_ready.
  - On out_ready: pc <= pc + PC_STEP, modulo 2^32 (wraps 0xFFFF_FFFC → 0) → S_REQ.
  - A fault is delivered like a normal instruction. The IFU does not stall on a fault; downstream traps and redirects.
- Redirect (highest priority, any state): pc <= {redirect_pc_i[31:2],2'b00}.
  - S_REQ, no handshake this cycle → stay in S_REQ; the new address appears next cycle.
  - S_REQ, handshake this cycle → S_WAIT with drop=1.
  - S_WAIT, no response this cycle → set drop=1.
  - S_WAIT, response this cycle → discard the response → S_REQ.
  - S_WAIT with drop already 1 → drop stays 1. Only one response is outstanding and the latest target is kept.
  - S_OUT (including out_ready=1 this cycle) → S_REQ, out_valid=0 next cycle, no pc increment. IF/ID flushes in the same cycle, so the instruction is treated as not transferred.
- Latency: memory accepts at cycle 0 and responds at cycle k → out_valid at k+1. Best-case throughput is 1 instruction per 3 cycles.

Decomposition:
- Shared package ysyx_24100006_defs holds:
  - IFU state encoding: S_REQ=2'd0, S_WAIT=2'd1, S_OUT=2'd2
  - RESET_PC default
  - instruction width constant (32)
- No sub-module; a single FSM plus the pc and output registers.

Test Plan:
- Reset, then memory with 0 wait states returning 0x00000413 → mem_req_addr=0x80000000 in the first cycle. out_valid one cycle after the response, pc_o=0x80000000, instruction_o=0x00000413. The next request address is 0x80000004.
- out_ready held low 5 cycles while out_valid=1 → pc_o, instruction_o and fault_o are constant. No new mem_req_valid until out_ready=1.
- Redirect to 0x80000103 in S_WAIT, response arriving 3 cycles later with 0xDEADBEEF → response consumed and dropped, out_valid never 1 for it. The next mem_req_addr is 0x80000100.
- Redirect in the same cycle as mem_resp_valid, and separately in the same cycle as out_ready → response/output discarded. The next request goes to the target, with no pc+4.
- Response with mem_resp_err=1 at pc 0x80000008 → out_valid with fault_o=1, pc_o=0x80000008. Fault clears on the next good fetch.
- reset asserted in S_WAIT → the next cycle shows out_valid=0 and mem_req_valid=1 with mem_req_addr=RESET_PC. Separately, pc=0xFFFFFFFC with out_ready → next mem_req_addr=0x00000000.
